// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Freezes the whole pipe on a memory wait, squashes wrong-path work on a
// taken branch (deferring it until memory is idle), inserts one bubble on a
// load-use dependency, and keeps saturating counters of each event.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       idex_rd,
  input  logic             idex_is_load,
  input  logic             idex_regwrite,
  input  logic             ex_branch_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] load_use_cnt
);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t state, state_nxt;
  logic   flush_pending, flush_pending_nxt;
  logic   mem_busy, load_use, do_flush, lu_stall;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Hazard detection terms; x0 is never a real producer.
  assign mem_busy = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
  assign load_use = idex_is_load & idex_regwrite & (idex_rd != 5'd0) &
                    ((id_rs1_used & (id_rs1 == idex_rd)) |
                     (id_rs2_used & (id_rs2 == idex_rd)));
  assign do_flush = ~mem_busy & (ex_branch_taken | flush_pending);
  assign lu_stall = ~mem_busy & ~do_flush & load_use;

  // Next-state logic: track memory waits and remember branches seen during them.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nxt         = state;
    flush_pending_nxt = flush_pending;
    case (state)
      RUN:      if (mem_busy)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (!mem_busy) state_nxt = RUN;
      default:                 state_nxt = RUN;
    endcase
    if (mem_busy && ex_branch_taken) flush_pending_nxt = 1'b1;
    else if (do_flush)               flush_pending_nxt = 1'b0;
  end

  // State and pending-flush registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      flush_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state         <= state_nxt;
      flush_pending <= flush_pending_nxt;
    end
  end

  // Pipeline control, strictly prioritised: reset > freeze > flush > load-use > run.
  always_comb begin
    pc_load     = 1'b1;
    ifid_load   = 1'b1;
    idex_load   = 1'b1;
    exmem_load  = 1'b1;
    memwb_load  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst || mem_busy) begin
      pc_load    = 1'b0;
      ifid_load  = 1'b0;
      idex_load  = 1'b0;
      exmem_load = 1'b0;
      memwb_load = 1'b0;
    end else if (do_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_load     = 1'b0;
      ifid_load   = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      load_use_cnt <= '0;
    end else begin
      if (mem_busy && stall_cnt != CNT_MAX)    stall_cnt    <= stall_cnt + CNT_W'(1);
      if (do_flush && flush_cnt != CNT_MAX)    flush_cnt    <= flush_cnt + CNT_W'(1);
      if (lu_stall && load_use_cnt != CNT_MAX) load_use_cnt <= load_use_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of each saturating performance counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_rs1_used, id_rs2_used  input  1 each  ID instruction reads that source.
REQ-006 SHALL have ports idex_rd  input  5, idex_is_load  input  1, idex_regwrite  input  1  producer fields of the ID/EX instruction.
REQ-007 SHALL have port ex_branch_taken  input  1  EX resolved a taken branch or jump; redirect PC.
REQ-008 SHALL have ports imem_read  input  1, imem_resp  input  1  instruction-memory request/response.
REQ-009 SHALL have ports dmem_req  input  1, dmem_resp  input  1  data-memory read-or-write request/response.
REQ-010 SHALL have ports pc_load, ifid_load, idex_load, exmem_load, memwb_load  output  1 each  pipeline register enables.
REQ-011 SHALL have ports ifid_flush, idex_bubble  output  1 each  load NOP into IF/ID and ID/EX respectively.
REQ-012 SHALL have ports stall_cnt, flush_cnt, load_use_cnt  output  CNT_W each  performance counters.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT; state register plus a 1-bit flush_pending register.
REQ-014 SHALL define mem_busy = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp).
REQ-015 SHALL define load_use = idex_is_load & idex_regwrite & (idex_rd != 0) & ((id_rs1_used & id_rs1 == idex_rd) | (id_rs2_used & id_rs2 == idex_rd)).
REQ-016 SHALL, whenever mem_busy=1 (either state), drive all five loads 0, ifid_flush 0, idex_bubble 0 (full freeze).
REQ-017 SHALL transition RUN->MEM_WAIT when mem_busy=1, MEM_WAIT->RUN on the first edge with mem_busy=0.
REQ-018 SHALL, while mem_busy=1, set flush_pending on ex_branch_taken=1; flush_pending SHALL hold until consumed.
REQ-019 SHALL define do_flush = ~mem_busy & (ex_branch_taken | flush_pending); flush_pending SHALL clear on the edge where do_flush=1.
REQ-020 SHALL, on do_flush, drive all loads 1, ifid_flush 1, idex_bubble 1, for exactly that cycle; load_use ignored.
REQ-021 SHALL, on ~mem_busy & ~do_flush & load_use, drive pc_load 0, ifid_load 0, idex_load 1, idex_bubble 1, exmem_load 1, memwb_load 1, ifid_flush 0.
REQ-022 SHALL otherwise drive all loads 1, ifid_flush 0, idex_bubble 0.
REQ-023 SHALL produce outputs combinationally from current state/flags and inputs; zero added latency.
REQ-024 SHALL priority-order: mem_busy > do_flush > load_use > normal.
REQ-025 SHALL increment stall_cnt each cycle mem_busy=1, flush_cnt each cycle do_flush=1, load_use_cnt each cycle REQ-021 applies.
REQ-026 SHALL saturate each counter at 2^CNT_W-1 (no wrap-around).
REQ-027 SHALL treat idex_rd=0 as never hazardous; load into x0 causes no stall.
REQ-028 SHALL give a load-use stall at most one bubble per load, since the bubble clears idex_is_load.

Reset
REQ-029 SHALL, while rst=1, force state=RUN, flush_pending=0, all counters 0, independent of clk.
REQ-030 SHALL, while rst=1, drive all loads 0, ifid_flush 0, idex_bubble 0.
REQ-031 SHALL, after rst deasserts mid-stall, resume in RUN with no pending flush; first post-reset cycle obeys REQ-016..REQ-022.

Verification
REQ-032 SHALL test load-use: idex_is_load=1, idex_regwrite=1, idex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle pc_load=0, ifid_load=0, idex_bubble=1; load_use_cnt=1.
REQ-033 SHALL test x0 load: idex_rd=0, id_rs1=0, id_rs1_used=1 -> all loads 1, no bubble, load_use_cnt stays 0.
REQ-034 SHALL test deferred flush: dmem_req=1, dmem_resp=0 for 3 cycles, ex_branch_taken=1 in the first -> loads 0 for 3 cycles, stall_cnt=3; next cycle ifid_flush=1, idex_bubble=1; flush_cnt=1.
REQ-035 SHALL test priority: ex_branch_taken=1 with load_use=1, mem idle -> flush outputs only, load_use_cnt unchanged.
REQ-036 SHALL test async reset: assert rst mid-MEM_WAIT between clock edges -> outputs 0 and counters 0 immediately; after release, imem_resp=1 -> all loads 1.
REQ-037 SHALL test saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15.
